// File: rtl/byte_striping_pkg.sv
// Shared defaults, derived widths and the active-lane-count sanitiser for the
// byte striping/un-striping blocks.
package byte_striping_pkg;

    localparam int LANES_DEF  = 4;
    localparam int WIDTH_DEF  = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int LANE_IDX_W = $clog2(LANES_DEF);
    localparam int PTR_W      = $clog2(DEPTH_DEF) + 1;

    // Anything other than a power of two in 1..lanes falls back to all lanes.
    function automatic int lane_cnt_sanitize(input int act, input int lanes);
        if (act < 1 || act > lanes || (act & (act - 1)) != 0) return lanes;
        return act;
    endfunction

endpackage

// File: rtl/byte_unstriping_rx_param_lane_fifo.sv
// Per-lane deskew FIFO: registered read (no fall-through), push accepted on a
// full FIFO only when a pop happens in the same cycle; otherwise drop is raised.
module lane_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             drop
);
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic             do_pop, do_push;

    // Extra MSB on the pointers distinguishes full from empty.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                     (wr_q[PTR_W-2:0] == rd_q[PTR_W-2:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign dout    = mem_q[rd_q[PTR_W-2:0]];
    assign wr_d    = wr_q + {{(PTR_W-1){1'b0}}, do_push};
    assign rd_d    = rd_q + {{(PTR_W-1){1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PTR_W-2:0]] <= din;
    end

endmodule

// File: rtl/byte_unstriping_rx_param.sv
// Receive-side byte un-striper: per-lane deskew FIFOs drained in strict
// round-robin lane order into a valid/ready output register.
module byte_unstriping_rx_param
    import byte_striping_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LANES*WIDTH-1:0]     data_in,
    input  logic [LANES-1:0]           valid_in,
    input  logic [$clog2(LANES):0]     active_lanes,
    output logic [WIDTH-1:0]           data,
    output logic                       valid,
    input  logic                       ready,
    output logic                       overflow
);
    localparam int LIW = $clog2(LANES);
    localparam int AW  = LIW + 1;

    logic [AW-1:0]                 act_q, act_d, act_san;
    logic [LIW-1:0]                rr_q, rr_d;
    logic [WIDTH-1:0]              data_q, data_d;
    logic                          valid_q, valid_d, ovf_q, ovf_d;
    logic [LANES-1:0]              push, pop, empty, full, drop;
    logic [LANES-1:0][WIDTH-1:0]   head;
    logic                          load, idle;

    assign act_san = AW'(lane_cnt_sanitize(int'(active_lanes), LANES));
    assign load    = (!valid_q || ready) && !empty[rr_q];
    assign idle    = (&empty) && !valid_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign push[g] = valid_in[g] && (act_q > AW'(g));
        assign pop[g]  = load && (rr_q == LIW'(g));
        lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[g]),
            .din   (data_in[g*WIDTH +: WIDTH]),
            .pop   (pop[g]),
            .dout  (head[g]),
            .empty (empty[g]),
            .full  (full[g]),
            .drop  (drop[g])
        );
    end

    always_comb begin
        act_d   = act_q;
        rr_d    = rr_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q || |(drop & full);
        if (load) begin
            data_d  = head[rr_q];
            valid_d = 1'b1;
            rr_d    = (({1'b0, rr_q} + AW'(1)) == act_q) ? '0 : rr_q + LIW'(1);
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        // Lane count may only change with nothing in flight.
        if (idle) begin
            act_d = act_san;
            rr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q   <= act_san;
            rr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            act_q   <= act_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_byte_unstriping_rx_param.sv
// Directed scenarios plus randomized traffic checked against a queue-based
// reference model of the un-striper.
module tb_byte_unstriping_rx_param;
    localparam int LANES = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic [3:0]  valid_in;
    logic [2:0]  active_lanes;
    logic [7:0]  data;
    logic        valid, ready, overflow;

    int vectors = 0;
    int errs    = 0;

    logic [7:0] mq [LANES][$];
    logic       mv, movf;
    logic [7:0] mdata;
    int         mrr, mact;

    byte_unstriping_rx_param #(.LANES(4), .WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .active_lanes(active_lanes), .data(data), .valid(valid),
        .ready(ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int legal_cnt(input int a);
        if ((a == 1 || a == 2 || a == 4 || a == 8) && a <= LANES) return a;
        return LANES;
    endfunction

    // Advance one clock: update the reference model with the current inputs,
    // then settle 1 time unit past the edge.
    task automatic step();
        bit ld, idle;
        if (reset) begin
            for (int i = 0; i < LANES; i++) mq[i].delete();
            mv = 0; mdata = 8'h00; movf = 0; mrr = 0;
            mact = legal_cnt(int'(active_lanes));
        end else begin
            idle = !mv;
            for (int i = 0; i < LANES; i++) if (mq[i].size() != 0) idle = 0;
            ld = (!mv || ready) && (mq[mrr].size() != 0);
            if (ld) begin
                mdata = mq[mrr].pop_front();
                mv    = 1;
                mrr   = (mrr + 1) % mact;
            end else if (mv && ready) begin
                mv = 0;
            end
            for (int i = 0; i < LANES; i++) begin
                if (valid_in[i] && i < mact) begin
                    if (mq[i].size() < DEPTH) mq[i].push_back(data_in[i*8 +: 8]);
                    else movf = 1;
                end
            end
            if (idle) begin
                mact = legal_cnt(int'(active_lanes));
                mrr  = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; valid_in = '0; ready = 1;
        step(); step();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; active_lanes = 3'd4; ready = 1;
        for (int i = 0; i < 2; i++) begin
            valid_in = 4'hF; data_in = $urandom;
            step();
        end
        vectors++;
        if ({valid, data, overflow} !== {1'b0, 8'h00, 1'b0}) begin
            errs++;
            $display("FAIL reset_state got v=%0b d=%h o=%0b want v=0 d=00 o=0", valid, data, overflow);
        end
        reset = 0; valid_in = 4'hF; data_in = 32'h13121110;
        step();
        valid_in = 4'h0;
        step();
        vectors++;
        if ({valid, data} !== {1'b1, 8'h10}) begin
            errs++;
            $display("FAIL reset_first_lane0 got v=%0b d=%h want v=1 d=10", valid, data);
        end
    endtask

    task automatic test_aligned();
        do_reset();
        valid_in = 4'hF; data_in = 32'hA3A2A1A0;
        step();
        valid_in = 4'h0;
        vectors++;
        if (valid !== 1'b0) begin
            errs++;
            $display("FAIL aligned_latency got v=%0b want v=0", valid);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({valid, data} !== {1'b1, 8'hA0 + 8'(i)}) begin
                errs++;
                $display("FAIL aligned_byte%0d got v=%0b d=%h want v=1 d=%h", i, valid, data, 8'hA0 + 8'(i));
            end
        end
        step();
        vectors++;
        if (valid !== 1'b0) begin
            errs++;
            $display("FAIL aligned_end got v=%0b want v=0", valid);
        end
    endtask

    task automatic test_skew();
        logic       ev [1:6];
        logic [7:0] ed [1:6];
        ev = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ed = '{8'hB0, 8'hB1, 8'h00, 8'hB2, 8'hB3, 8'h00};
        do_reset();
        valid_in = 4'b1011; data_in = 32'hB300B1B0;
        step();
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) begin valid_in = 4'b0100; data_in = 32'h00B20000; end
            else valid_in = 4'b0000;
            step();
            vectors++;
            if (valid !== ev[k] || (ev[k] && data !== ed[k])) begin
                errs++;
                $display("FAIL skew_cycle%0d got v=%0b d=%h want v=%0b d=%h", k, valid, data, ev[k], ed[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        valid_in = 4'hF; data_in = 32'hC3C2C1C0;
        step();
        valid_in = 4'h0;
        step();
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({valid, data} !== {1'b1, 8'hC0}) begin
                errs++;
                $display("FAIL bp_hold%0d got v=%0b d=%h want v=1 d=c0", i, valid, data);
            end
            step();
        end
        ready = 1;
        for (int i = 1; i < 4; i++) begin
            step();
            vectors++;
            if ({valid, data} !== {1'b1, 8'hC0 + 8'(i)}) begin
                errs++;
                $display("FAIL bp_byte%0d got v=%0b d=%h want v=1 d=%h", i, valid, data, 8'hC0 + 8'(i));
            end
        end
        step();
        vectors++;
        if (valid !== 1'b0) begin
            errs++;
            $display("FAIL bp_end got v=%0b want v=0", valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_tail [4];
        exp_tail = '{8'h51, 8'h52, 8'h53, 8'hD1};
        do_reset();
        ready = 0;
        for (int i = 0; i < 6; i++) begin
            valid_in = 4'b0001; data_in = {24'h0, 8'hD0 + 8'(i)};
            step();
            vectors++;
            if (overflow !== (i == 5) || (i >= 1 && {valid, data} !== {1'b1, 8'hD0})) begin
                errs++;
                $display("FAIL ovf_push%0d got v=%0b d=%h o=%0b want o=%0b", i, valid, data, overflow, i == 5);
            end
        end
        valid_in = 4'h0; ready = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({valid, data, overflow} !== {1'b0, 8'hD0, 1'b1}) begin
                errs++;
                $display("FAIL ovf_stall%0d got v=%0b d=%h o=%0b want v=0 d=d0 o=1", i, valid, data, overflow);
            end
        end
        valid_in = 4'b1110; data_in = 32'h53525100;
        step();
        valid_in = 4'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({valid, data, overflow} !== {1'b1, exp_tail[i], 1'b1}) begin
                errs++;
                $display("FAIL ovf_resume%0d got v=%0b d=%h o=%0b want v=1 d=%h o=1", i, valid, data, overflow, exp_tail[i]);
            end
        end
    endtask

    task automatic test_lane_count();
        logic [7:0] exp2 [4];
        exp2 = '{8'hE0, 8'hE1, 8'hE0, 8'hE1};
        active_lanes = 3'd4;
        do_reset();
        active_lanes = 3'd2;
        step();
        valid_in = 4'hF; data_in = 32'hE3E2E1E0;
        step();
        step();
        valid_in = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            vectors++;
            if ({valid, data, overflow} !== {1'b1, exp2[i], 1'b0}) begin
                errs++;
                $display("FAIL lanes2_byte%0d got v=%0b d=%h o=%0b want v=1 d=%h o=0", i, valid, data, overflow, exp2[i]);
            end
        end
        step();
        vectors++;
        if (valid !== 1'b0) begin
            errs++;
            $display("FAIL lanes2_end got v=%0b want v=0", valid);
        end
        // 3 is not a power of two, so all four lanes are used.
        active_lanes = 3'd3;
        step();
        valid_in = 4'hF; data_in = 32'hF3F2F1F0;
        step();
        valid_in = 4'h0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if ({valid, data} !== {1'b1, 8'hF0 + 8'(i)}) begin
                errs++;
                $display("FAIL lanes_illegal_byte%0d got v=%0b d=%h want v=1 d=%h", i, valid, data, 8'hF0 + 8'(i));
            end
        end
        active_lanes = 3'd4;
    endtask

    task automatic test_random();
        for (int ph = 0; ph < 8; ph++) begin
            active_lanes = 3'($urandom_range(0, 7));
            do_reset();
            for (int c = 0; c < 80; c++) begin
                if (c < 60) begin
                    valid_in = 4'($urandom);
                    data_in  = $urandom;
                    ready    = ($urandom_range(0, 3) <= ph % 4);
                    if ($urandom_range(0, 15) == 0) active_lanes = 3'($urandom_range(0, 7));
                end else begin
                    valid_in = 4'h0;
                    ready    = 1;
                end
                step();
                vectors++;
                if (valid !== mv || data !== mdata || overflow !== movf) begin
                    errs++;
                    $display("FAIL random_p%0d_c%0d got v=%0b d=%h o=%0b want v=%0b d=%h o=%0b",
                             ph, c, valid, data, overflow, mv, mdata, movf);
                end
            end
        end
    endtask

    initial begin
        reset = 1; valid_in = '0; data_in = '0; active_lanes = 3'd4; ready = 1;
        mv = 0; movf = 0; mdata = 8'h00; mrr = 0; mact = LANES;
        test_reset();
        test_aligned();
        test_skew();
        test_backpressure();
        test_overflow();
        test_lane_count();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/byte_unstriping_rx_param.md
Name: byte_unstriping_rx_param

Overview:
- Parametrised receive-side byte un-striper: collects bytes arriving on LANES parallel lanes and re-serialises them, in lane order 0,1,..,N-1,0,.., onto one output byte stream.
- Successor to the fixed 4-lane bytestripingRX.
- Adds per-lane deskew FIFOs, a valid/ready output handshake, a runtime-selectable active lane count and a sticky overflow flag.
- Sits between the per-lane receive logic and the packet/byte consumer.

Parameters:
- LANES, 4, number of physical lanes; power of two, 2..8.
- WIDTH, 8, bits per lane symbol.
- DEPTH, 4, entries per lane deskew FIFO; power of two, ≥2.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- valid_in  in  LANES  per-lane byte-valid strobe.
- active_lanes  in  $clog2(LANES)+1  number of lanes in use: 1, 2, 4 .. LANES.
- data  out  WIDTH  reassembled byte.
- valid  out  1  data holds a byte.
- ready  in  1  downstream accepts data when valid&&ready.
- overflow  out  1  sticky: a byte was dropped on a full lane FIFO.

Behaviour:
- Reset (synchronous, active-high; evaluated at the clk edge):
  - data=0, valid=0, overflow=0.
  - Round-robin pointer rr=0; all FIFOs emptied.
  - act_q <= active_lanes.
  - Reset mid-operation discards all buffered bytes; no partial output after reset.
- Config:
  - act_q is re-sampled from active_lanes only when idle: all FIFOs empty and valid=0.
  - When act_q is re-sampled, rr is forced to 0.
  - Illegal values (0, non-power-of-two, >LANES) are treated as LANES.
  - valid_in[i] is ignored for i ≥ act_q.
- Lane FIFO push: valid_in[i]=1 and i<act_q writes data_in lane i into FIFO i.
- Output load condition: (!valid || ready) && FIFO[rr] non-empty.
  - On load: data <= head of FIFO[rr]; FIFO[rr] is popped; valid <= 1; rr <= (rr+1) mod act_q.
  - Else if valid && ready: valid <= 0, data holds its last value.
  - Else: data and valid are held.
- Ordering:
  - Strict lane order.
  - If FIFO[rr] is empty the stream stalls, even when other lanes hold data. This is the deskew behaviour.
- Latency: a byte pushed at edge k into an empty FIFO whose lane equals rr, with the output register free, appears with valid=1 after edge k+1.
- Throughput: one byte per clock while FIFO[rr] is non-empty and ready=1.
- Backpressure: while valid=1 and ready=0, data and valid are held stable and rr does not advance.
- Full FIFO:
  - Push with no pop in the same cycle drops the byte and sets overflow=1; overflow stays 1 until reset.
  - Push and pop in the same cycle on a full FIFO is accepted, no overflow.
- Empty FIFO with simultaneous push and pop request: no pop that cycle; the byte is available the next cycle (no fall-through).
- Pointers:
  - FIFO pointers wrap mod DEPTH, with an extra bit for full/empty.
  - rr wraps mod act_q.

Decomposition:
- Shared package byte_striping_pkg holds:
  - Default LANES, WIDTH, DEPTH.
  - Function lane_cnt_sanitize(active_lanes, LANES).
  - Widths: LANE_IDX_W=$clog2(LANES), PTR_W=$clog2(DEPTH)+1.
- Sub-module lane_fifo (WIDTH, DEPTH):
  - Ports: push, din, pop, dout, empty, full, drop.
  - Instantiated LANES times in a generate loop.
- Top level contains the rr pointer, the config sampler, the output register and the overflow OR.

Test Plan:
(LANES=4, WIDTH=8, DEPTH=4, active_lanes=4, ready=1 unless stated)
- Reset: assert reset 2 cycles with traffic on valid_in -> data=0x00, valid=0, overflow=0; first byte after release comes from lane 0.
- Aligned: one cycle with valid_in=4'b1111, lanes=0xA0,0xA1,0xA2,0xA3 -> valid high 4 consecutive cycles starting one cycle after the push edge, data=A0,A1,A2,A3.
- Skew: lanes 0,1,3 push 0xB0,0xB1,0xB3 at cycle 0; lane 2 pushes 0xB2 at cycle 3 -> output B0,B1, then valid=0 until B2 appears one cycle after the cycle-3 push edge, then B3; no reordering.
- Backpressure: aligned burst 0xC0..0xC3 with ready=0 for 5 cycles after first valid -> data=0xC0 stable with valid=1 for 5 cycles, then C0..C3 in order, no loss.
- Overflow: ready=0; lane 0 pushes 0xD0..0xD5 on 6 consecutive cycles -> 0xD0 in output register, D1..D4 in FIFO, D5 dropped, overflow=1 from the 6th push onward and persisting; after ready=1 the stream resumes with D0, then stalls waiting on lane 1.
- Lane count: active_lanes=2 sampled while idle; lanes 0..3 push 0xE0..0xE3 twice -> output E0,E1,E0,E1; lanes 2,3 ignored; overflow stays 0.
